fetch_unit: RTL and testbench

Instruction fetch front end that consumes the program counter. It reads the current PC value, issues word reads to instruction memory over a req/ack handshake, and pulses the PC increment on each accepted fetch. Fetched instructions are buffered with their addresses in a 2-entry queue toward decode. Branch redirects from execute are forwarded to the PC load port, and the queue and any in-flight fetch are flushed.

---
 rtl/fetch_unit.sv | 139 +++++++++++++
 tb/tb_fetch_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: drives PC increment/load, fetches words over a
// req/ack memory handshake and buffers them with their addresses toward decode.
module fetch_unit #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned ADDRWIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [ADDRWIDTH-1:0] PC_IN,
  output logic                 PC_INCR,
  output logic                 PC_LD,
  output logic [ADDRWIDTH-1:0] PC_TARGET,
  input  logic                 REDIRECT,
  input  logic [ADDRWIDTH-1:0] REDIRECT_ADDR,
  output logic                 MEM_REQ,
  output logic [ADDRWIDTH-1:0] MEM_ADDR,
  input  logic                 MEM_ACK,
  input  logic [DATAWIDTH-1:0] MEM_DATA,
  output logic                 INSTR_VALID,
  output logic [DATAWIDTH-1:0] INSTR,
  output logic [ADDRWIDTH-1:0] INSTR_PC,
  input  logic                 INSTR_READY
);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t               state;
  logic                 tail_vld;
  logic [DATAWIDTH-1:0] tail_data;
  logic [ADDRWIDTH-1:0] tail_addr;

  logic       pop;
  logic       push;
  logic       space;
  logic [1:0] count;
  logic [1:0] count_next;

  // Head entry lives directly in the output registers; tail is the second slot.
  assign pop        = INSTR_VALID & INSTR_READY;
  assign push       = (state == REQ) & MEM_ACK & ~REDIRECT;
  assign count      = 2'(INSTR_VALID) + 2'(tail_vld);
  assign count_next = count + 2'(push) - 2'(pop);
  assign space      = (count_next < 2'd2);

  assign PC_INCR   = push & ~RST;
  assign PC_LD     = REDIRECT & ~RST;
  assign PC_TARGET = (REDIRECT & ~RST) ? REDIRECT_ADDR : '0;

  // Fetch FSM: a request is issued only once a queue slot is guaranteed.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      MEM_REQ  <= 1'b0;
      MEM_ADDR <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!REDIRECT && space) begin
            state    <= REQ;
            MEM_REQ  <= 1'b1;
            MEM_ADDR <= PC_IN;
          end
        end
        REQ: begin
          if (MEM_ACK) begin
            if (!REDIRECT && space) begin
              MEM_ADDR <= PC_IN + ADDRWIDTH'(1);
            end else begin
              state   <= IDLE;
              MEM_REQ <= 1'b0;
            end
          end else if (REDIRECT) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // The outstanding request must complete; its data is dropped.
          if (MEM_ACK) begin
            state   <= IDLE;
            MEM_REQ <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          MEM_REQ <= 1'b0;
        end
      endcase
    end
  end

  // Two-entry FIFO; a redirect flushes it and overrides any same-cycle pop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      INSTR_VALID <= 1'b0;
      INSTR       <= '0;
      INSTR_PC    <= '0;
      tail_vld    <= 1'b0;
      tail_data   <= '0;
      tail_addr   <= '0;
    end else if (REDIRECT) begin
      INSTR_VALID <= 1'b0;
      tail_vld    <= 1'b0;
    end else begin
      case ({push, pop})
        2'b01: begin
          INSTR_VALID <= tail_vld;
          INSTR       <= tail_data;
          INSTR_PC    <= tail_addr;
          tail_vld    <= 1'b0;
        end
        2'b10: begin
          if (!INSTR_VALID) begin
            INSTR_VALID <= 1'b1;
            INSTR       <= MEM_DATA;
            INSTR_PC    <= MEM_ADDR;
          end else begin
            tail_vld  <= 1'b1;
            tail_data <= MEM_DATA;
            tail_addr <= MEM_ADDR;
          end
        end
        2'b11: begin
          if (tail_vld) begin
            INSTR     <= tail_data;
            INSTR_PC  <= tail_addr;
            tail_data <= MEM_DATA;
            tail_addr <= MEM_ADDR;
          end else begin
            INSTR    <= MEM_DATA;
            INSTR_PC <= MEM_ADDR;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: expected fetch stream follows the program
// order from the last reset/redirect target, checked by a decoupled monitor.
module tb_fetch_unit;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } fetch_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [AW-1:0] PC_IN;
  logic          PC_INCR;
  logic          PC_LD;
  logic [AW-1:0] PC_TARGET;
  logic          REDIRECT = 1'b0;
  logic [AW-1:0] REDIRECT_ADDR = '0;
  logic          MEM_REQ;
  logic [AW-1:0] MEM_ADDR;
  logic          MEM_ACK = 1'b0;
  logic [DW-1:0] MEM_DATA = '0;
  logic          INSTR_VALID;
  logic [DW-1:0] INSTR;
  logic [AW-1:0] INSTR_PC;
  logic          INSTR_READY = 1'b0;

  int errors = 0;
  int checks = 0;

  fetch_t        exp_q[$];
  logic [AW-1:0] pc = '0;
  logic [AW-1:0] pc_force_val = '0;
  logic [AW-1:0] exp_seq = '0;
  logic [AW-1:0] prev_addr = '0;
  logic          pc_force = 1'b0;
  logic          push_now = 1'b0;
  logic          poisoned = 1'b0;
  logic          prev_pending = 1'b0;
  logic          last_rst = 1'b0;
  logic          mem_busy = 1'b0;
  logic          done = 1'b0;
  int            mem_wait = 0;
  int            n_fetch = 0;
  int            mon_cnt = 0;
  int unsigned   dly_lo = 0;
  int unsigned   dly_hi = 0;

  fetch_unit #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
    .CLK(CLK), .RST(RST), .PC_IN(PC_IN), .PC_INCR(PC_INCR), .PC_LD(PC_LD),
    .PC_TARGET(PC_TARGET), .REDIRECT(REDIRECT), .REDIRECT_ADDR(REDIRECT_ADDR),
    .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_ACK(MEM_ACK), .MEM_DATA(MEM_DATA),
    .INSTR_VALID(INSTR_VALID), .INSTR(INSTR), .INSTR_PC(INSTR_PC),
    .INSTR_READY(INSTR_READY)
  );

  always #5 CLK = ~CLK;

  // Architectural PC register driven by the DUT's strobes.
  assign PC_IN = pc;
  always @(posedge CLK) begin
    if (pc_force) pc <= pc_force_val;
    else if (PC_LD) pc <= PC_TARGET;
    else if (PC_INCR) pc <= pc + AW'(1);
  end

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock cycle: drive inputs, answer memory, update the reference model.
  task automatic step(input logic rst, input logic redir, input logic [AW-1:0] raddr,
                      input int ready_pct);
    logic acc;
    @(posedge CLK);
    #1;
    if (last_rst) begin
      check("rst_mem_req", 32'(MEM_REQ), 32'd0);
      check("rst_mem_addr", MEM_ADDR, 32'd0);
      check("rst_instr_valid", 32'(INSTR_VALID), 32'd0);
      check("rst_instr", INSTR, 32'd0);
      check("rst_instr_pc", INSTR_PC, 32'd0);
    end
    if (prev_pending) begin
      check("req_held", 32'(MEM_REQ), 32'd1);
      check("addr_held", MEM_ADDR, prev_addr);
    end
    RST           = rst;
    REDIRECT      = redir;
    REDIRECT_ADDR = raddr;
    pc_force      = rst;
    INSTR_READY   = (int'($urandom_range(99)) < ready_pct);
    if (MEM_REQ && !mem_busy) begin
      mem_busy = 1'b1;
      mem_wait = int'($urandom_range(dly_hi, dly_lo));
    end
    MEM_ACK  = mem_busy && (mem_wait == 0);
    MEM_DATA = MEM_ACK ? memf(MEM_ADDR) : $urandom();
    if (mem_busy) begin
      if (MEM_ACK) mem_busy = 1'b0;
      else mem_wait--;
    end
    #1;
    check("pc_ld", 32'(PC_LD), 32'(redir && !rst));
    check("pc_target", PC_TARGET, (redir && !rst) ? raddr : 32'd0);
    acc = !rst && MEM_ACK && !redir && !poisoned;
    check("pc_incr", 32'(PC_INCR), 32'(acc));
    push_now = acc;
    if (acc) begin
      check("fetch_addr", MEM_ADDR, exp_seq);
      exp_q.push_back('{addr: MEM_ADDR, data: MEM_DATA});
      exp_seq = exp_seq + AW'(1);
      n_fetch++;
    end
    prev_pending = MEM_REQ && !MEM_ACK && !rst;
    prev_addr    = MEM_ADDR;
    if (MEM_ACK) poisoned = 1'b0;
    else if (redir && MEM_REQ) poisoned = 1'b1;
    if (rst) begin
      exp_q.delete();
      exp_seq  = pc_force_val;
      poisoned = 1'b0;
      mem_busy = 1'b0;
    end else if (redir) begin
      exp_q.delete();
      exp_seq = raddr;
    end
    last_rst = rst;
  endtask

  task automatic do_reset(input logic [AW-1:0] pcv, input logic redir);
    pc_force_val = pcv;
    step(1'b1, redir, 32'h0BAD_0000, 100);
    n_fetch = 0;
  endtask

  // Monitor: compares the queue head against the scoreboard on every pop.
  always @(negedge CLK) begin
    fetch_t e;
    if (!done && !RST && !REDIRECT) begin
      mon_cnt = exp_q.size() - (push_now ? 1 : 0);
      check("instr_valid", 32'(INSTR_VALID), 32'(mon_cnt > 0));
      if (INSTR_VALID && INSTR_READY && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("instr_pc", INSTR_PC, e.addr);
        check("instr", INSTR, e.data);
      end
    end
  end

  initial begin
    logic [AW-1:0] ra;
    int unsigned   r;

    // Back-to-back fetches with instant acks.
    dly_lo = 0; dly_hi = 0;
    do_reset(32'h10, 1'b0);
    repeat (6) step(1'b0, 1'b0, '0, 100);
    check("b2b_fetches", 32'(n_fetch), 32'd5);

    // Ack delayed three cycles.
    dly_lo = 3; dly_hi = 3;
    do_reset(32'h20, 1'b0);
    repeat (6) step(1'b0, 1'b0, '0, 100);
    check("slow_ack_fetches", 32'(n_fetch), 32'd1);

    // Decode stalled: exactly two entries, then request stops.
    dly_lo = 0; dly_hi = 0;
    do_reset(32'h40, 1'b0);
    repeat (10) step(1'b0, 1'b0, '0, 0);
    check("stall_fetches", 32'(n_fetch), 32'd2);
    check("stall_mem_req", 32'(MEM_REQ), 32'd0);
    repeat (10) step(1'b0, 1'b0, '0, 100);
    check("resume_fetches", 32'(n_fetch > 2), 32'd1);

    // Redirect while a request waits, late ack discarded.
    dly_lo = 4; dly_hi = 4;
    do_reset(32'h30, 1'b0);
    repeat (2) step(1'b0, 1'b0, '0, 100);
    dly_lo = 0; dly_hi = 0;
    step(1'b0, 1'b1, 32'h100, 100);
    repeat (8) step(1'b0, 1'b0, '0, 100);
    check("drain_fetches", 32'(n_fetch), 32'd4);

    // Redirect coinciding with an ack.
    do_reset(32'h60, 1'b0);
    repeat (3) step(1'b0, 1'b0, '0, 100);
    step(1'b0, 1'b1, 32'h200, 100);
    repeat (4) step(1'b0, 1'b0, '0, 100);

    // PC wrap.
    do_reset(32'hFFFF_FFFF, 1'b0);
    repeat (4) step(1'b0, 1'b0, '0, 100);
    check("wrap_fetches", 32'(n_fetch), 32'd3);

    // Reset mid-request with redirect asserted.
    dly_lo = 5; dly_hi = 5;
    do_reset(32'h70, 1'b0);
    repeat (3) step(1'b0, 1'b0, '0, 100);
    do_reset(32'h80, 1'b1);
    step(1'b0, 1'b0, '0, 100);

    // Random traffic.
    dly_lo = 0; dly_hi = 3;
    repeat (3000) begin
      r  = $urandom_range(99);
      ra = $urandom();
      if (r < 1) do_reset(ra, 1'($urandom_range(1)));
      else step(1'b0, r < 6, ra, 70);
    end
    repeat (6) step(1'b0, 1'b0, '0, 100);

    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
